// File: rtl/counter_updown_mod_if.sv
// Control/status bundle for counter_updown_mod: step controls in, count and event flags out.
interface counter_updown_mod_if #(
    parameter int unsigned WIDTH = 8
);
    logic             en;
    logic             up;
    logic             load;
    logic [WIDTH-1:0] load_data;
    logic [WIDTH-1:0] max_value;
    logic             sat;
    logic             ovf_clr;
    logic [WIDTH-1:0] count;
    logic             tc;
    logic             wrap;
    logic             ovf;

    modport master (
        output en, up, load, load_data, max_value, sat, ovf_clr,
        input  count, tc, wrap, ovf
    );

    modport slave (
        input  en, up, load, load_data, max_value, sat, ovf_clr,
        output count, tc, wrap, ovf
    );
endinterface

// File: rtl/counter_updown_mod.sv
// N-bit up/down counter with programmable terminal value, load, wrap pulse and sticky overflow.
// Saturate mode is compiled in only when COUNTER_UPDOWN_SAT_EN is defined; otherwise it always wraps.
module counter_updown_mod #(
    parameter int unsigned     WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input logic                  clk,
    input logic                  reset,
    counter_updown_mod_if.slave  bus
);
    logic [WIDTH-1:0] count_q, count_d;
    logic             wrap_q, wrap_d;
    logic             ovf_q, ovf_d;
    logic             sat_mode;
    logic             at_top;
    logic             at_zero;
    logic             end_evt;

`ifdef COUNTER_UPDOWN_SAT_EN
    assign sat_mode = bus.sat;
`else
    logic unused_sat;
    assign unused_sat = bus.sat;
    assign sat_mode   = 1'b0;
`endif

    assign at_top  = (count_q >= bus.max_value);
    assign at_zero = (count_q == '0);
    assign end_evt = bus.en & ~bus.load & (bus.up ? at_top : at_zero);

    always_comb begin
        count_d = count_q;
        if (bus.load) begin
            count_d = (bus.load_data > bus.max_value) ? bus.max_value : bus.load_data;
        end else if (bus.en) begin
            if (bus.up) begin
                if (at_top) count_d = sat_mode ? bus.max_value : '0;
                else        count_d = count_q + WIDTH'(1);
            end else begin
                // Above range while counting down: snap to the terminal value, no end event.
                if (count_q > bus.max_value) count_d = bus.max_value;
                else if (at_zero)            count_d = sat_mode ? '0 : bus.max_value;
                else                         count_d = count_q - WIDTH'(1);
            end
        end
    end

    // Set beats clear on the sticky flag.
    assign wrap_d = end_evt & ~sat_mode;
    assign ovf_d  = end_evt | (ovf_q & ~bus.ovf_clr);

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= RESET_VALUE;
            wrap_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            wrap_q  <= wrap_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.count = count_q;
    assign bus.wrap  = wrap_q;
    assign bus.ovf   = ovf_q;
    assign bus.tc    = end_evt & ~reset;
endmodule
